// File: rtl/ibwt_top.sv
// Inverse Burrows-Wheeler transform: loads one block, ranks it by LF-mapping, walks it back and streams the result.
// Optional build macro IBWT_STRIP_SENTINEL_EN drops the trailing sentinel from the output stream.
module ibwt_top #(
    parameter int unsigned STRING_LEN = 8,
    parameter logic [7:0]  SENTINEL   = 8'h24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] input_string_char,
    output logic [7:0] output_string_char,
    output logic       valid_out,
    output logic       busy,
    output logic       error
);
    localparam int unsigned IW = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
    localparam int unsigned CW = $clog2(STRING_LEN + 1);
`ifdef IBWT_STRIP_SENTINEL_EN
    localparam int unsigned OUT_LEN = STRING_LEN - 1;
`else
    localparam int unsigned OUT_LEN = STRING_LEN;
`endif
    localparam logic [IW-1:0] LAST_ROW  = IW'(STRING_LEN - 1);
    localparam logic [IW-1:0] LAST_WALK = IW'(STRING_LEN - 2);
    localparam logic [IW-1:0] LAST_SEND = IW'(OUT_LEN - 1);

    typedef enum logic [1:0] {LOAD, RANK, WALK, SEND} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ctr, ctr_nxt;
    logic [IW-1:0] p, p_nxt;
    logic [CW-1:0] sent_cnt, sent_cnt_nxt;
    logic [CW-1:0] sent_total;
    logic [CW-1:0] rank_acc;
    logic [IW-1:0] lf_row;
    logic [7:0]    send_char;
    logic [7:0]    out_char_nxt;
    logic          valid_nxt, busy_nxt, error_nxt;
    logic          l_we, lf_we, ob_we;

    logic [7:0]    l_mem   [STRING_LEN];
    logic [IW-1:0] lf_mem  [STRING_LEN];
    logic [7:0]    out_buf [STRING_LEN-1];

    // LF rank of the row selected by ctr: smaller bytes anywhere plus equal bytes in earlier rows.
    always_comb begin
        rank_acc = '0;
        for (int j = 0; j < int'(STRING_LEN); j++) begin
            if (l_mem[j] < l_mem[ctr]) begin
                rank_acc = rank_acc + CW'(1);
            end else if ((l_mem[j] == l_mem[ctr]) && (IW'(j) < ctr)) begin
                rank_acc = rank_acc + CW'(1);
            end
        end
        lf_row = IW'(rank_acc);
    end

    assign sent_total = sent_cnt + CW'(l_mem[ctr] == SENTINEL);
    assign send_char  = (ctr == LAST_ROW) ? SENTINEL : out_buf[ctr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= LOAD;
            ctr                <= '0;
            p                  <= '0;
            sent_cnt           <= '0;
            output_string_char <= '0;
            valid_out          <= 1'b0;
            busy               <= 1'b0;
            error              <= 1'b0;
        end else begin
            state              <= state_nxt;
            ctr                <= ctr_nxt;
            p                  <= p_nxt;
            sent_cnt           <= sent_cnt_nxt;
            output_string_char <= out_char_nxt;
            valid_out          <= valid_nxt;
            busy               <= busy_nxt;
            error              <= error_nxt;
        end
    end

    // Block storage carries no reset; a fresh block overwrites every row before use.
    always_ff @(posedge clk) begin
        if (l_we) begin
            l_mem[ctr] <= input_string_char;
        end
        if (lf_we) begin
            lf_mem[ctr] <= lf_row;
        end
        if (ob_we) begin
            out_buf[LAST_WALK - ctr] <= l_mem[p];
        end
    end

    always_comb begin
        state_nxt    = state;
        ctr_nxt      = ctr;
        p_nxt        = p;
        sent_cnt_nxt = sent_cnt;
        out_char_nxt = output_string_char;
        valid_nxt    = 1'b0;
        error_nxt    = 1'b0;
        l_we         = 1'b0;
        lf_we        = 1'b0;
        ob_we        = 1'b0;
        case (state)
            LOAD: begin
                // busy stays high for one cycle after an abort or send, so gate on it too.
                if (valid_in && !busy) begin
                    l_we = 1'b1;
                    if (ctr == LAST_ROW) begin
                        ctr_nxt      = '0;
                        sent_cnt_nxt = '0;
                        state_nxt    = RANK;
                    end else begin
                        ctr_nxt = ctr + IW'(1);
                    end
                end
            end
            RANK: begin
                lf_we        = 1'b1;
                sent_cnt_nxt = sent_total;
                if (ctr == LAST_ROW) begin
                    ctr_nxt = '0;
                    p_nxt   = '0;
                    if (sent_total != CW'(1)) begin
                        error_nxt = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = WALK;
                    end
                end else begin
                    ctr_nxt = ctr + IW'(1);
                end
            end
            WALK: begin
                ob_we = 1'b1;
                p_nxt = lf_mem[p];
                if (ctr == LAST_WALK) begin
                    ctr_nxt   = '0;
                    state_nxt = SEND;
                end else begin
                    ctr_nxt = ctr + IW'(1);
                end
            end
            SEND: begin
                valid_nxt    = 1'b1;
                out_char_nxt = send_char;
                if (ctr == LAST_SEND) begin
                    ctr_nxt   = '0;
                    state_nxt = LOAD;
                end else begin
                    ctr_nxt = ctr + IW'(1);
                end
            end
            default: state_nxt = LOAD;
        endcase
        busy_nxt = (state != LOAD) || (state_nxt != LOAD);
    end

endmodule

// File: doc/ibwt_top.md
# ibwt_top

Inverse Burrows-Wheeler transform engine, the receive-side counterpart of the forward BWT pipeline. It collects one STRING_LEN-character BWT block from a byte stream and rebuilds the original string by LF-mapping. It then streams the rebuilt string out one byte per cycle, using the same valid-qualified byte interface as the forward transform output.

## Interface
- STRING_LEN, 8: block length in characters, sentinel included; legal range 2..64.
- SENTINEL, 8'h24: end-of-string marker; must be the unique, strictly smallest byte in the block.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- valid_in  input  1  input_string_char is valid this cycle.
- input_string_char  input  8  BWT (last-column) character, in row order 0..STRING_LEN-1.
- output_string_char  output  8  reconstructed character, registered.
- valid_out  output  1  output_string_char is valid this cycle.
- busy  output  1  high outside LOAD; valid_in is ignored while busy.
- error  output  1  one-cycle pulse when the block has no sentinel or more than one.

## Operation
- States:
  - LOAD: reset state.
    - Each cycle with valid_in high, the byte is written to L[ctr] and ctr increments.
    - The STRING_LEN-th accepted byte moves the block to RANK; ctr clears.
  - RANK: one row per cycle, i = 0..STRING_LEN-1.
    - lf[i] = (count of j with L[j] < L[i]) + (count of j < i with L[j] == L[i]).
    - All comparisons are unsigned 8-bit.
    - lf entries are $clog2(STRING_LEN) bits wide; the counts cannot overflow.
    - A sentinel counter runs in parallel.
    - At the end of RANK, a sentinel count other than 1 pulses error for one cycle and returns to LOAD with no output. Otherwise go to WALK.
  - WALK: STRING_LEN-1 cycles.
    - p starts at 0, the row that begins with the sentinel.
    - Step k: out_buf[STRING_LEN-2-k] = L[p]; then p = lf[p].
    - out_buf[STRING_LEN-1] = SENTINEL.
  - SEND: emit out_buf[0..last] in order, one per cycle, with valid_out high; then return to LOAD.
- Duplicate characters are resolved only by the occurrence term in lf, which is stable by row index.
- Rows are not checked for being a valid rotation set. Any block with exactly one sentinel produces output; a malformed block produces deterministic but meaningless output.

## Timing
- Reset values: output_string_char = 0, valid_out = 0, busy = 0, error = 0; state LOAD, ctr = 0.
- Let t be the cycle in which the last input byte is accepted. N = STRING_LEN.
- busy is high from cycle t+1 through the final SEND cycle.
- Error case: the error pulse occurs in cycle t+N+1. busy is low again from t+N+2.
- Normal case:
  - valid_out is high for consecutive cycles t+2N+1 through t+2N+OUT_LEN, with no gaps.
  - OUT_LEN = N by default (see Configuration).
  - busy drops in the cycle after the last valid_out.
  - A valid_in sampled in that cycle is accepted as byte 0 of the next block.
- While valid_out is low, output_string_char holds its last value.
- valid_in gaps during LOAD are allowed; only qualified bytes count.
- Reset asserted in any state takes effect at the next edge: all outputs return to reset values, the partial block is discarded, and the state returns to LOAD.

## Configuration
- IBWT_STRIP_SENTINEL_EN
  - Defined: the trailing sentinel is not emitted. OUT_LEN = N-1, and valid_out spans t+2N+1..t+3N-1.
  - Undefined: all N characters are emitted, the sentinel last. OUT_LEN = N.

## Test plan
- N=8, input "g$abcdef" -> valid_out for 8 cycles starting t+17, carrying "abcdefg$"; busy falls at t+25.
- Input "aaaaaaa$" (tie handling) -> output "aaaaaaa$".
- Input "abcdefgh" (no sentinel) -> error pulse at t+9, no valid_out. Then "g$abcdef" -> correct output.
- Two blocks, with the second block's first byte presented in the cycle busy falls -> both outputs correct, back-to-back.
- Assert rst during WALK, then send "aaaaaaa$" -> no output from the aborted block; the new block gives "aaaaaaa$".
- IBWT_STRIP_SENTINEL_EN defined, input "g$abcdef" -> 7 valid cycles carrying "abcdefg".
